monostable_pulse_spacer: RTL and testbench
==========================================

# monostable_pulse_spacer

Single-clock pulse pacer on the fast (source) side of a monostable domain crossing. Turns arbitrarily dense single-cycle event pulses, including back-to-back, into single-cycle output pulses with a guaranteed minimum spacing, so a downstream monostable crossing into a slower clock never merges or drops events. Events that arrive faster than the spacing are queued in a saturating pending counter. Overflow is flagged sticky.

## Interface
Parameters:
- GAP_CYCLES, 32, minimum number of `out`-low cycles after each `out` pulse. Range ≥1. The default covers a 50 MHz to 4.98 MHz crossing with 3 destination cycles of margin.
- CNT_W, 4, width of the pending-event counter. Capacity is 2^CNT_W−1 events.

Ports:
- clk  in  1  block clock.
- rst_n  in  1  reset. **One clock; reset is synchronous and active-low.**
- in  in  1  event strobe. Every cycle high counts as one event.
- clr_ovf  in  1  clears `overflow`.
- out  out  1  paced event pulse, exactly 1 cycle wide. Feeds the crossing's `in`.
- busy  out  1  high when state ≠ IDLE.
- pending  out  CNT_W  events queued but not yet issued.
- overflow  out  1  sticky; an event was dropped because the queue was full.

## Operation
- States:
  - IDLE: `out`=0.
  - PULSE: `out`=1, lasts exactly one cycle.
  - GAP: `out`=0, down-counter running.
- IDLE → PULSE when `in`=1 or `pending`>0. Otherwise stay in IDLE.
- PULSE → GAP always. Load the gap counter with GAP_CYCLES−1.
- GAP: decrement the counter each cycle.
  - At counter 0, go to PULSE if `in`=1 or `pending`>0.
  - Otherwise go to IDLE.
- Issue = transition into PULSE. Every issue consumes one event: either the current `in` or one from `pending`.
- Pending counter update, all in one cycle:
  - `in` and issue together: unchanged.
  - `in` alone: +1.
  - Issue alone: −1.
- Saturation: `in`=1, no issue, and `pending`=2^CNT_W−1 → event dropped, `pending` unchanged, `overflow` set.
  - `in` at full with a simultaneous issue is not an overflow.
- `overflow` stays set until `clr_ovf`=1. If `clr_ovf` and a new drop happen in the same cycle, set wins.
- Arithmetic: `pending` is unsigned CNT_W bits. It never wraps in either direction. The gap counter is ceil(log2(GAP_CYCLES+1)) bits.

## Timing
- All outputs registered.
- Reset values: `out`=0, `busy`=0, `pending`=0, `overflow`=0, state IDLE, gap counter 0.
- Latency: `in` high in cycle t while IDLE → `out` high in cycle t+1.
- Spacing:
  - Consecutive `out` pulses are separated by exactly GAP_CYCLES low cycles while a backlog exists.
  - The pulse period is GAP_CYCLES+1.
  - `out` is never high two cycles in a row.
- An event arriving in the last GAP cycle (counter 0) is issued in the next cycle. It adds no extra idle cycle.
- Reset mid-operation: `rst_n` low at any edge forces reset values at that edge.
  - A PULSE in progress is cut.
  - The queue is discarded.
- `busy` is high from the PULSE cycle through the final GAP cycle. It falls in the cycle the FSM returns to IDLE.

## Structure
- Shared package `sd_pulse_pkg`:
  - state enum typedef `pulse_state_t` {IDLE, PULSE, GAP};
  - default GAP_CYCLES constant, reused by the crossing instantiation.
- One sub-module is natural: `gap_counter`, a loadable down-counter with a zero flag.
- The FSM and pending counter live in the top module.

## Test plan
The bench instantiates GAP_CYCLES=4, CNT_W=2 unless stated otherwise.
- Single event: `in` high 1 cycle at t.
  - `out` high only at t+1.
  - `busy` high t+1..t+5, low at t+6.
  - `pending` stays 0.
- Burst of 3 back-to-back `in` cycles.
  - `out` pulses at t+1, t+6, t+11.
  - `pending` sequence 1, 2, then decrements to 0.
  - `overflow`=0.
- Burst of 6 back-to-back: `pending` saturates at 3.
  - `overflow`=1, and exactly 4 `out` pulses follow, 5 cycles apart.
  - `clr_ovf` pulse → `overflow`=0.
- `in` exactly at the final GAP cycle after a single event.
  - The next `out` comes on the following cycle, period 5, `pending` stays 0.
- Reset mid-burst: `rst_n` low 1 cycle while `pending`=2 in GAP.
  - All outputs at reset values the next cycle.
  - No further `out` without new `in`.
- Default parameters, with the crossing into a 4.98 MHz domain: 10 back-to-back events → exactly 10 destination-domain pulses counted.

Source files
------------

// File: rtl/sd_pulse_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | sd_pulse_pkg : shared types and constants for the pulse spacer/crossing   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package sd_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } pulse_state_t;

    // 50 MHz -> 4.98 MHz with 3 destination cycles of margin
    localparam int C_DEFAULT_GAP_CYCLES = 32;

endpackage : sd_pulse_pkg
`default_nettype wire

// File: rtl/gap_counter.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | gap_counter : loadable down-counter with zero flag, holds at zero         |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module gap_counter #(
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_dec,
    output logic         o_zero
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_zero = (r_cnt == '0);

endmodule : gap_counter
`default_nettype wire

// File: rtl/monostable_pulse_spacer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | monostable_pulse_spacer : paces dense event strobes into 1-cycle pulses   |
// | separated by GAP_CYCLES low cycles, with a saturating pending queue.      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module monostable_pulse_spacer
    import sd_pulse_pkg::*;
#(
    parameter int GAP_CYCLES = C_DEFAULT_GAP_CYCLES,
    parameter int CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in,
    input  logic             i_clr_ovf,
    output logic             o_out,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_pending,
    output logic             o_overflow
);

    localparam int               C_GAP_W    = $clog2(GAP_CYCLES + 1);
    localparam logic [C_GAP_W-1:0] C_GAP_LOAD = C_GAP_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] C_PEND_MAX = '1;

    pulse_state_t     r_state;
    pulse_state_t     w_next;
    logic [CNT_W-1:0] r_pending;
    logic [CNT_W-1:0] w_pend_next;
    logic             r_out;
    logic             r_busy;
    logic             r_ovf;
    logic             w_req;
    logic             w_issue;
    logic             w_drop;
    logic             w_gap_zero;

    gap_counter #(
        .W (C_GAP_W)
    ) u_gap_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (r_state == PULSE),
        .i_load_val (C_GAP_LOAD),
        .i_dec      (r_state == GAP),
        .o_zero     (w_gap_zero)
    );

    assign w_req = i_in | (r_pending != '0);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = w_req ? PULSE : IDLE;
            PULSE:   w_next = GAP;
            GAP:     if (w_gap_zero) w_next = w_req ? PULSE : IDLE;
            default: w_next = IDLE;
        endcase
    end

    assign w_issue = (w_next == PULSE);

    // An issue consumes the live strobe first, so only a lone side moves the queue
    always_comb begin
        w_pend_next = r_pending;
        w_drop      = 1'b0;
        if (i_in && !w_issue) begin
            if (r_pending == C_PEND_MAX) begin
                w_drop = 1'b1;
            end else begin
                w_pend_next = r_pending + 1'b1;
            end
        end else if (!i_in && w_issue && (r_pending != '0)) begin
            w_pend_next = r_pending - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_pending <= '0;
            r_out     <= 1'b0;
            r_busy    <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_pending <= w_pend_next;
            r_out     <= w_issue;
            r_busy    <= (w_next != IDLE);
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (i_clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

    assign o_out      = r_out;
    assign o_busy     = r_busy;
    assign o_pending  = r_pending;
    assign o_overflow = r_ovf;

endmodule : monostable_pulse_spacer
`default_nettype wire

// File: tb/tb_monostable_pulse_spacer.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | tb_monostable_pulse_spacer : directed + random bench against a           |
// | time-based reference model, plus a toggle crossing into 4.98 MHz.        |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_monostable_pulse_spacer;

    localparam int GAP  = 4;
    localparam int CW   = 2;
    localparam int PMAX = (1 << CW) - 1;
    localparam int BIG  = 1000;

    logic          clk  = 1'b0;
    logic          sclk = 1'b0;
    logic          rst_n;
    logic          r_in;
    logic          r_clr;
    logic          o_out;
    logic          o_busy;
    logic [CW-1:0] o_pend;
    logic          o_ovf;

    logic          d_in;
    logic          d_clr;
    logic          d_out;
    logic          d_busy;
    logic [3:0]    d_pend;
    logic          d_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state: cycles since the last pulse and the queued backlog
    int m_pending;
    int m_since;
    bit m_ovf;
    bit m_out;
    bit m_busy;

    logic       x_tgl   = 1'b0;
    logic [2:0] x_sync  = 3'b000;
    int         x_count = 0;

    always #10    clk  = ~clk;
    always #100.4 sclk = ~sclk;

    monostable_pulse_spacer #(
        .GAP_CYCLES (GAP),
        .CNT_W      (CW)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in       (r_in),
        .i_clr_ovf  (r_clr),
        .o_out      (o_out),
        .o_busy     (o_busy),
        .o_pending  (o_pend),
        .o_overflow (o_ovf)
    );

    monostable_pulse_spacer u_dut_dflt (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_in       (d_in),
        .i_clr_ovf  (d_clr),
        .o_out      (d_out),
        .o_busy     (d_busy),
        .o_pending  (d_pend),
        .o_overflow (d_ovf)
    );

    // Toggle-style monostable crossing into the slow domain
    always @(posedge clk) begin
        if (!rst_n) x_tgl <= 1'b0;
        else if (d_out) x_tgl <= ~x_tgl;
    end

    always @(posedge sclk) begin
        x_sync <= {x_sync[1:0], x_tgl};
        if (x_sync[2] != x_sync[1]) x_count <= x_count + 1;
    end

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model(input bit a_in, input bit a_clr, input bit a_rst_n);
        bit issue;
        bit drop;
        if (!a_rst_n) begin
            m_pending = 0;
            m_ovf     = 1'b0;
            m_out     = 1'b0;
            m_busy    = 1'b0;
            m_since   = BIG;
        end else begin
            issue = (m_since + 1 >= GAP + 1) && (a_in || (m_pending > 0));
            drop  = 1'b0;
            if (a_in && !issue) begin
                if (m_pending == PMAX) drop = 1'b1;
                else m_pending++;
            end else if (!a_in && issue) begin
                m_pending--;
            end
            if (drop) m_ovf = 1'b1;
            else if (a_clr) m_ovf = 1'b0;
            m_since = issue ? 0 : ((m_since < BIG) ? m_since + 1 : BIG);
            m_out   = issue;
            m_busy  = (m_since <= GAP);
        end
    endtask

    task automatic step(input bit a_in, input bit a_clr, input bit a_rst_n);
        r_in  = a_in;
        r_clr = a_clr;
        rst_n = a_rst_n;
        @(posedge clk);
        model(a_in, a_clr, a_rst_n);
        #1;
        chk("out",      8'(o_out),  8'(m_out));
        chk("busy",     8'(o_busy), 8'(m_busy));
        chk("pending",  8'(o_pend), 8'(m_pending));
        chk("overflow", 8'(o_ovf),  8'(m_ovf));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        int base;
        r_in  = 1'b0;
        r_clr = 1'b0;
        rst_n = 1'b0;
        d_in  = 1'b0;
        d_clr = 1'b0;
        m_since = BIG;

        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        idle(2);

        // single event
        step(1'b1, 1'b0, 1'b1);
        idle(8);

        // burst of 3
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        idle(15);

        // burst of 6 saturates the queue
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b1);
        chk("ovf_after_burst6", 8'(o_ovf), 8'd1);
        idle(22);
        step(1'b0, 1'b1, 1'b1);
        chk("ovf_cleared", 8'(o_ovf), 8'd0);
        idle(3);

        // event landing in the final GAP cycle
        step(1'b1, 1'b0, 1'b1);
        idle(4);
        step(1'b1, 1'b0, 1'b1);
        idle(10);

        // reset while pending=2 in GAP
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        chk("pending_before_rst", 8'(o_pend), 8'd2);
        step(1'b0, 1'b0, 1'b0);
        idle(12);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(99) < 40), ($urandom_range(99) < 5),
                 !($urandom_range(199) == 0));
        end
        idle(20);

        // default parameters through a 4.98 MHz crossing
        base = x_count;
        d_in = 1'b1;
        repeat (10) @(posedge clk);
        #1 d_in = 1'b0;
        for (int i = 0; i < 2000 && (x_count - base) < 10; i++) @(posedge clk);
        repeat (200) @(posedge clk);
        chk("xing_count", 8'(x_count - base), 8'd10);
        chk("dflt_pending", 8'(d_pend), 8'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule : tb_monostable_pulse_spacer
`default_nettype wire
